// File: rtl/uart_tx_arbiter_if.sv
//==============================================================================
// Module      : uart_tx_arbiter_if
// Description : Source request bus, UART handshake and arbiter status lines
//               shared between the UART transmit arbiter and its environment.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
    parameter int N_SRC = 3
) ();
    logic [N_SRC-1:0]   req_valid;
    logic [8*N_SRC-1:0] req_byte;
    logic [N_SRC-1:0]   req_last;
    logic [N_SRC-1:0]   req_ready;
    logic               o_tx_done;
    logic               tx_data_valid;
    logic [7:0]         tx_byte;
    logic [N_SRC-1:0]   grant;
    logic               busy;
    logic               timeout_err;

    // Arbiter side: owns the UART start request and the status outputs.
    modport master (
        input  req_valid, req_byte, req_last, o_tx_done,
        output req_ready, tx_data_valid, tx_byte, grant, busy, timeout_err
    );

    // Environment side: message sources plus the UART itself.
    modport slave (
        output req_valid, req_byte, req_last, o_tx_done,
        input  req_ready, tx_data_valid, tx_byte, grant, busy, timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
//==============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmitter between N_SRC message sources.
//               Round-robin at message granularity, byte sequencing through
//               the UART valid/done handshake, per-state watchdog abort.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int N_SRC       = 3,
    parameter int TIMEOUT_CYC = 20000,
    parameter int CNT_W       = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    uart_tx_arbiter_if.master  bus
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [N_SRC-1:0]   r_grant;
    logic [IDX_W-1:0]   r_gidx;
    logic [IDX_W-1:0]   r_ptr;
    logic [7:0]         r_tx_byte;
    logic               r_last;
    logic               r_tx_valid;
    logic               r_busy;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_wd_cnt;

    logic               w_pick_found;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [IDX_W-1:0]   w_scan_idx;
    logic [N_SRC-1:0]   w_grant_pick;
    logic               w_grant_load;
    logic               w_accept;
    logic               w_release;
    logic               w_timeout;
    logic [7:0]         w_src_byte [N_SRC];

    // Split the flat byte bus into one lane per source.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_unpack
        assign w_src_byte[gi] = bus.req_byte[8*gi +: 8];
    end

    // Round-robin search: first requester strictly after the last owner, with wrap.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_scan_idx   = r_ptr;
        w_grant_pick = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (w_scan_idx == IDX_W'(N_SRC - 1)) begin
                w_scan_idx = '0;
            end else begin
                w_scan_idx = w_scan_idx + IDX_W'(1);
            end
            if (!w_pick_found && bus.req_valid[w_scan_idx]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_scan_idx;
            end
        end
        w_grant_pick[w_pick_idx] = 1'b1;
    end

    // Next-state logic; the watchdog abort overrides every normal transition.
    always_comb begin
        w_state_next = r_state;
        w_grant_load = 1'b0;
        w_accept     = 1'b0;
        w_release    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_found) begin
                    w_state_next = S_LOAD;
                    w_grant_load = 1'b1;
                end
            end
            S_LOAD: begin
                if (bus.req_valid[r_gidx]) begin
                    w_state_next = S_SEND;
                    w_accept     = 1'b1;
                end
            end
            S_SEND: begin
                // A UART already busy on entry counts as having taken the byte.
                if (!bus.o_tx_done) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.o_tx_done) begin
                    if (r_last) begin
                        w_state_next = S_IDLE;
                        w_release    = 1'b1;
                    end else begin
                        w_state_next = S_LOAD;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if ((r_state != S_IDLE) && (r_wd_cnt == CNT_W'(TIMEOUT_CYC - 1))) begin
            w_state_next = S_IDLE;
            w_accept     = 1'b0;
            w_release    = 1'b1;
            w_timeout    = 1'b1;
        end
    end

    // State register, registered outputs and watchdog counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_wd_cnt   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_tx_valid <= (w_state_next == S_SEND);
            r_busy     <= (w_state_next != S_IDLE);
            r_timeout  <= w_timeout;
            if ((w_state_next != r_state) || (w_state_next == S_IDLE)) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + CNT_W'(1);
            end
        end
    end

    // Ownership and priority pointer; the released owner drops to lowest priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= IDX_W'(N_SRC - 1);
        end else if (w_grant_load) begin
            r_grant <= w_grant_pick;
            r_gidx  <= w_pick_idx;
        end else if (w_release) begin
            r_grant <= '0;
            r_ptr   <= r_gidx;
        end
    end

    // Byte latch: tx_byte stays stable from one accepted byte to the next.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_byte <= '0;
            r_last    <= 1'b0;
        end else if (w_accept) begin
            r_tx_byte <= w_src_byte[r_gidx];
            r_last    <= bus.req_last[r_gidx];
        end
    end

    assign bus.req_ready     = (r_state == S_LOAD) ? r_grant : '0;
    assign bus.tx_data_valid = r_tx_valid;
    assign bus.tx_byte       = r_tx_byte;
    assign bus.grant         = r_grant;
    assign bus.busy          = r_busy;
    assign bus.timeout_err   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//==============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter: byte-queue sources,
//               a 10-cycle UART model and a message-level round-robin model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } item_t;

    logic clk;
    logic rst_n;

    uart_tx_arbiter_if #(.N_SRC(3)) bus ();

    uart_tx_arbiter #(
        .N_SRC       (3),
        .TIMEOUT_CYC (16),
        .CNT_W       (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         checks   = 0;
    int         failures = 0;

    item_t      src_q [3][$];
    logic [7:0] acc   [3][$];
    int         glog  [$];
    int         ready_cnt [3];
    int         tx_starts = 0;
    int         to_cnt    = 0;
    logic [7:0] last_start_byte = '0;
    int         mptr = 2;
    logic [2:0] prev_grant = '0;
    logic [2:0] prev_req   = '0;
    logic       prev_txv   = 1'b0;
    logic       rst_prev   = 1'b1;
    logic       last_acc   = 1'b0;
    logic [2:0] fire_mask  = '0;
    logic       uart_start = 1'b0;
    int         uart_cnt   = 0;
    logic       stuck      = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic int oidx(input logic [2:0] g);
        case (g)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    // Round-robin rule: first requester after the last owner, modulo 3.
    function automatic int rr(input int p, input logic [2:0] m);
        for (int k = 1; k <= 3; k++) begin
            if (m[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    function automatic item_t head(input int s);
        if (src_q[s].size() > 0) return src_q[s][0];
        return '0;
    endfunction

    // Sources and UART react just after each rising edge.
    initial begin
        item_t h0, h1, h2;
        bus.req_valid = '0;
        bus.req_byte  = '0;
        bus.req_last  = '0;
        bus.o_tx_done = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                uart_cnt      = 0;
                bus.o_tx_done = 1'b1;
            end else if (uart_start) begin
                bus.o_tx_done = 1'b0;
                uart_cnt      = 10;
            end else if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) bus.o_tx_done = 1'b1;
            end
            for (int i = 0; i < 3; i++) begin
                if (fire_mask[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
            fire_mask  = '0;
            uart_start = 1'b0;
            h0 = head(0);
            h1 = head(1);
            h2 = head(2);
            bus.req_valid = {src_q[2].size() != 0, src_q[1].size() != 0, src_q[0].size() != 0};
            bus.req_byte  = {h2.b, h1.b, h0.b};
            bus.req_last  = {h2.last, h1.last, h0.last};
        end
    end

    // Compare process: checks DUT outputs against the message-level model each cycle.
    always @(negedge clk) begin
        int o;
        int e;
        logic [7:0] v;
        if (!rst_n) begin
            if (!rst_prev) begin
                chk("rst_grant", bus.grant, 0);
                chk("rst_busy", bus.busy, 0);
                chk("rst_txv", bus.tx_data_valid, 0);
                chk("rst_txbyte", bus.tx_byte, 0);
                chk("rst_timeout", bus.timeout_err, 0);
                chk("rst_ready", bus.req_ready, 0);
            end
            for (int i = 0; i < 3; i++) acc[i].delete();
            mptr       = 2;
            prev_grant = '0;
            prev_txv   = 1'b0;
            last_acc   = 1'b0;
            fire_mask  = '0;
            uart_start = 1'b0;
        end else begin
            chk("grant_onehot0", $onehot0(bus.grant), 1);
            chk("busy_vs_grant", bus.busy, |bus.grant);
            chk("ready_only_owner", bus.req_ready & ~bus.grant, 0);
            if (bus.tx_data_valid) chk("txv_needs_busy", bus.busy, 1);
            if (bus.timeout_err) chk("timeout_clears_grant", {bus.grant, bus.tx_data_valid}, 0);
            if (prev_grant != 0 && bus.grant != 0) chk("grant_stable", bus.grant, prev_grant);
            if (prev_grant == 0 && bus.grant != 0) begin
                e = rr(mptr, prev_req);
                chk("grant_rr", bus.grant, (e < 0) ? 0 : (32'd1 << e));
                glog.push_back(oidx(bus.grant));
                last_acc = 1'b0;
            end
            if (prev_grant != 0 && bus.grant == 0) begin
                o = oidx(prev_grant);
                if (bus.timeout_err) begin
                    to_cnt++;
                    if (o >= 0) acc[o].delete();
                end else if (o >= 0) begin
                    chk("msg_complete", {last_acc, acc[o].size() == 0}, 2'b11);
                end
                mptr = o;
            end
            if (bus.tx_data_valid && !prev_txv) begin
                o = oidx(bus.grant);
                tx_starts++;
                last_start_byte = bus.tx_byte;
                if (o < 0 || acc[o].size() == 0) begin
                    chk("tx_byte_accepted", 0, 1);
                end else begin
                    v = acc[o].pop_front();
                    chk("tx_byte", bus.tx_byte, v);
                end
            end
            fire_mask = bus.req_valid & bus.req_ready;
            for (int i = 0; i < 3; i++) begin
                if (bus.req_ready[i]) ready_cnt[i]++;
                if (fire_mask[i] && src_q[i].size() > 0) begin
                    acc[i].push_back(src_q[i][0].b);
                    if (src_q[i][0].last) last_acc = 1'b1;
                end
            end
            uart_start = bus.tx_data_valid && bus.o_tx_done && (uart_cnt == 0) && !stuck;
            prev_grant = bus.grant;
            prev_txv   = bus.tx_data_valid;
        end
        prev_req = bus.req_valid;
        rst_prev = rst_n;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input int s, input logic [7:0] b, input logic last);
        item_t it;
        it.b    = b;
        it.last = last;
        src_q[s].push_back(it);
    endtask

    task automatic wait_idle(input int budget);
        logic done;
        done = 1'b0;
        for (int n = 0; n < budget; n++) begin
            cyc(1);
            if (!bus.busy && src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("idle_reached", done, 1);
    endtask

    task automatic wait_starts(input int target, input int budget);
        logic done;
        done = 1'b0;
        for (int n = 0; n < budget; n++) begin
            cyc(1);
            if (tx_starts >= target) begin
                done = 1'b1;
                break;
            end
        end
        chk("starts_reached", done, 1);
    endtask

    task automatic chk_log(input string nm, input int e0, input int e1, input int e2,
                           input int e3, input int e4, input int e5, input int n);
        int ex [6];
        ex = '{e0, e1, e2, e3, e4, e5};
        chk({nm, "_len"}, glog.size(), n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_%0d", nm, i), (glog.size() > i) ? glog[i] : 99, ex[i]);
        end
    endtask

    initial begin
        logic [7:0] msg2 [12];
        int base_r;
        int base_t;
        int cnt;
        logic seen;
        msg2 = '{8'h53, 8'h49, 8'h2D, 8'h53, 8'h49, 8'h4D, 8'h31, 8'h2D, 8'h50, 8'h2D, 8'h23, 8'h0D};
        for (int i = 0; i < 3; i++) ready_cnt[i] = 0;

        // Power-on reset: all outputs zero.
        rst_n = 1'b0;
        cyc(3);
        chk("por_grant", bus.grant, 0);
        chk("por_busy", bus.busy, 0);
        chk("por_txv", bus.tx_data_valid, 0);
        chk("por_timeout", bus.timeout_err, 0);
        rst_n = 1'b1;
        cyc(2);

        // Twelve-byte message from src0, with first-byte latency pinned.
        base_r = ready_cnt[0];
        base_t = tx_starts;
        glog.delete();
        for (int i = 0; i < 12; i++) push(0, msg2[i], i == 11);
        cyc(1);
        chk("lat_c0_grant", bus.grant, 0);
        cyc(1);
        chk("lat_c1_grant", bus.grant, 3'b001);
        chk("lat_c1_ready", bus.req_ready, 3'b001);
        chk("lat_c1_txv", bus.tx_data_valid, 0);
        cyc(1);
        chk("lat_c2_txv", bus.tx_data_valid, 1);
        chk("lat_c2_byte", bus.tx_byte, 8'h53);
        wait_idle(400);
        chk("msg12_ready_pulses", ready_cnt[0] - base_r, 12);
        chk("msg12_tx_starts", tx_starts - base_t, 12);
        chk_log("msg12_owner", 0, 0, 0, 0, 0, 0, 1);

        // Reset held three cycles in the middle of a src2 message.
        base_t = tx_starts;
        for (int i = 0; i < 4; i++) push(2, 8'h50 + 8'(i), i == 3);
        wait_starts(base_t + 2, 100);
        rst_n = 1'b0;
        src_q[2].delete();
        cyc(3);
        chk("midrst_grant", bus.grant, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_txv", bus.tx_data_valid, 0);
        rst_n = 1'b1;
        cyc(1);

        // Three sources, two 2-byte messages each, all raised together.
        glog.delete();
        for (int m = 0; m < 2; m++) begin
            for (int s = 0; s < 3; s++) begin
                for (int j = 0; j < 2; j++) push(s, 8'(8'h80 + s * 16 + m * 4 + j), j == 1);
            end
        end
        wait_idle(800);
        chk_log("rr3", 0, 1, 2, 0, 1, 2, 6);

        // Src1 keeps requesting single-byte messages while src2 waits.
        glog.delete();
        push(1, 8'hA1, 1'b1);
        push(1, 8'hA2, 1'b1);
        push(2, 8'hB1, 1'b1);
        wait_idle(300);
        chk_log("alt", 1, 2, 1, 0, 0, 0, 3);

        // UART never drops done: watchdog abort sixteen cycles into SEND.
        stuck = 1'b1;
        glog.delete();
        push(0, 8'hC0, 1'b1);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            cyc(1);
            if (bus.tx_data_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wd_send_seen", seen, 1);
        cnt  = 0;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            cyc(1);
            cnt++;
            if (bus.timeout_err) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wd_pulse_seen", seen, 1);
        chk("wd_latency", cnt, 16);
        chk("wd_grant", bus.grant, 0);
        chk("wd_txv", bus.tx_data_valid, 0);
        cyc(1);
        chk("wd_pulse_width", bus.timeout_err, 0);
        stuck = 1'b0;
        glog.delete();
        push(0, 8'hC1, 1'b1);
        push(1, 8'hC2, 1'b1);
        wait_idle(200);
        chk_log("wd_skip", 1, 0, 0, 0, 0, 0, 2);

        // Reset during WAIT of the fifth byte; the message restarts from byte 0.
        base_t = tx_starts;
        for (int i = 0; i < 8; i++) push(2, 8'h60 + 8'(i), i == 7);
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            cyc(1);
            if (tx_starts >= base_t + 5 && !bus.tx_data_valid && bus.busy) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wait5_reached", seen, 1);
        rst_n = 1'b0;
        src_q[2].delete();
        cyc(1);
        chk("r6_busy", bus.busy, 0);
        chk("r6_txv", bus.tx_data_valid, 0);
        chk("r6_grant", bus.grant, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        glog.delete();
        base_t = tx_starts;
        for (int i = 0; i < 8; i++) push(2, 8'h60 + 8'(i), i == 7);
        wait_starts(base_t + 1, 20);
        chk("r6_first_byte", last_start_byte, 8'h60);
        wait_idle(300);
        chk("r6_full_resend", tx_starts - base_t, 8);
        chk_log("r6_owner", 2, 0, 0, 0, 0, 0, 1);

        chk("timeouts_total", to_cnt, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench exceeded time bound");
    end

endmodule

`default_nettype wire
